// File: rtl/i2c_master_seq.sv
// Register-access sequencer: expands a write/read command into an entry list
// for i2c_master_core and collects ACK status and read bytes from its results.
module i2c_master_seq #(
  parameter int unsigned MAX_LEN = 8
) (
  input  logic        RESET_N,
  input  logic        CLK,
  input  logic        CMD_GO,
  input  logic        CMD_RW,
  input  logic [6:0]  CMD_DEV,
  input  logic [7:0]  CMD_REG,
  input  logic [3:0]  CMD_LEN,
  input  logic [63:0] CMD_WDATA,
  output logic        CMD_BUSY,
  output logic        CMD_DONE,
  output logic        CMD_ERR,
  output logic [63:0] CMD_RDATA,
  output logic        I2C_GO,
  input  logic        I2C_DONE,
  output logic [7:0]  I2C_RUN_NUM,
  output logic        snd_vld,
  input  logic        snd_rdy,
  output logic [7:0]  snd_dat,
  output logic [4:0]  snd_ctl,
  input  logic        rcv_vld,
  output logic        rcv_rdy,
  input  logic [7:0]  rcv_dat,
  input  logic        rcv_ack
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT, S_FIN} state_t;

  state_t      state;
  logic        rw_q;
  logic [6:0]  dev_q;
  logic [7:0]  reg_q;
  logic [3:0]  len_q;
  logic [63:0] wdata_q;
  logic [3:0]  n_q;
  logic [3:0]  idx;
  logic [3:0]  rcnt;
  logic [3:0]  go_len;
  logic [3:0]  last_idx;
  logic [2:0]  rbyte;
  logic [12:0] first_ent;
  logic [12:0] next_ent;

  function automatic logic [3:0] eff_len(input logic [3:0] len);
    if (len == 4'd0)             return 4'd1;
    else if (len > 4'(MAX_LEN))  return 4'(MAX_LEN);
    else                         return len;
  endfunction

  // Entry encoding {ctl, dat}; ctl bits: 0 start, 1 drive, 2 receive, 3 stop, 4 repeat.
  function automatic logic [12:0] entry(input logic rw, input logic [6:0] dev,
                                        input logic [7:0] regad, input logic [63:0] wdata,
                                        input logic [3:0] len, input logic [3:0] i);
    logic [4:0] ctl;
    logic [7:0] dat;
    logic [2:0] k;
    ctl = '0;
    dat = '0;
    k   = 3'(i - 4'd2);
    if (i == 4'd0) begin
      ctl = 5'b00011;
      dat = {dev, 1'b0};
    end else if (i == 4'd1) begin
      ctl = 5'b00010;
      dat = regad;
    end else if (rw && i == 4'd2) begin
      ctl = 5'b10010;
      dat = {dev, 1'b1};
    end else if (rw) begin
      ctl = 5'b00100;
    end else begin
      ctl = 5'b00010;
      dat = wdata[{k, 3'b000} +: 8];
    end
    if (i == (rw ? len + 4'd2 : len + 4'd1)) ctl[3] = 1'b1;
    return {ctl, dat};
  endfunction

  always_comb begin
    go_len    = eff_len(CMD_LEN);
    first_ent = entry(CMD_RW, CMD_DEV, CMD_REG, CMD_WDATA, go_len, 4'd0);
    next_ent  = entry(rw_q, dev_q, reg_q, wdata_q, len_q, idx + 4'd1);
    last_idx  = n_q - 4'd1;
    rbyte     = 3'(rcnt - 4'd3);
  end

  assign I2C_RUN_NUM = {4'd0, n_q};
  assign rcv_rdy     = CMD_BUSY;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= S_IDLE;
      rw_q      <= 1'b0;
      dev_q     <= '0;
      reg_q     <= '0;
      len_q     <= '0;
      wdata_q   <= '0;
      n_q       <= '0;
      idx       <= '0;
      rcnt      <= '0;
      I2C_GO    <= 1'b0;
      snd_vld   <= 1'b0;
      snd_dat   <= '0;
      snd_ctl   <= '0;
      CMD_BUSY  <= 1'b0;
      CMD_DONE  <= 1'b0;
      CMD_ERR   <= 1'b0;
      CMD_RDATA <= '0;
    end else begin
      CMD_DONE <= 1'b0;
      // Results follow entry order; rcnt selects the entry each result belongs to.
      if (rcv_vld && rcv_rdy && rcnt < n_q) begin
        if (rw_q && rcnt >= 4'd3) CMD_RDATA[{rbyte, 3'b000} +: 8] <= rcv_dat;
        else if (!rcv_ack)        CMD_ERR <= 1'b1;
        rcnt <= rcnt + 4'd1;
      end
      case (state)
        S_IDLE: if (CMD_GO) begin
          rw_q               <= CMD_RW;
          dev_q              <= CMD_DEV;
          reg_q              <= CMD_REG;
          len_q              <= go_len;
          wdata_q            <= CMD_WDATA;
          n_q                <= CMD_RW ? go_len + 4'd3 : go_len + 4'd2;
          idx                <= '0;
          rcnt               <= '0;
          {snd_ctl, snd_dat} <= first_ent;
          snd_vld            <= 1'b1;
          I2C_GO             <= 1'b1;
          CMD_BUSY           <= 1'b1;
          CMD_ERR            <= 1'b0;
          CMD_RDATA          <= '0;
          state              <= S_RUN;
        end
        S_RUN: if (snd_vld && snd_rdy) begin
          if (idx == last_idx) begin
            snd_vld            <= 1'b0;
            {snd_ctl, snd_dat} <= '0;
            state              <= S_WAIT;
          end else begin
            idx                <= idx + 4'd1;
            {snd_ctl, snd_dat} <= next_ent;
          end
        end
        S_WAIT: if (I2C_DONE) begin
          I2C_GO   <= 1'b0;
          CMD_DONE <= 1'b1;
          CMD_BUSY <= 1'b0;
          state    <= S_FIN;
        end
        S_FIN: if (!I2C_DONE) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_seq.sv
// Directed bench for i2c_master_seq: a small core model answers every entry
// and a vector table holds the hand-computed outcome of each command.
module tb_i2c_master_seq;

  logic        RESET_N, CLK;
  logic        CMD_GO, CMD_RW;
  logic [6:0]  CMD_DEV;
  logic [7:0]  CMD_REG;
  logic [3:0]  CMD_LEN;
  logic [63:0] CMD_WDATA;
  logic        CMD_BUSY, CMD_DONE, CMD_ERR;
  logic [63:0] CMD_RDATA;
  logic        I2C_GO, I2C_DONE;
  logic [7:0]  I2C_RUN_NUM;
  logic        snd_vld, snd_rdy;
  logic [7:0]  snd_dat;
  logic [4:0]  snd_ctl;
  logic        rcv_vld, rcv_rdy;
  logic [7:0]  rcv_dat;
  logic        rcv_ack;

  i2c_master_seq #(.MAX_LEN(8)) dut (
    .RESET_N(RESET_N), .CLK(CLK),
    .CMD_GO(CMD_GO), .CMD_RW(CMD_RW), .CMD_DEV(CMD_DEV), .CMD_REG(CMD_REG),
    .CMD_LEN(CMD_LEN), .CMD_WDATA(CMD_WDATA),
    .CMD_BUSY(CMD_BUSY), .CMD_DONE(CMD_DONE), .CMD_ERR(CMD_ERR), .CMD_RDATA(CMD_RDATA),
    .I2C_GO(I2C_GO), .I2C_DONE(I2C_DONE), .I2C_RUN_NUM(I2C_RUN_NUM),
    .snd_vld(snd_vld), .snd_rdy(snd_rdy), .snd_dat(snd_dat), .snd_ctl(snd_ctl),
    .rcv_vld(rcv_vld), .rcv_rdy(rcv_rdy), .rcv_dat(rcv_dat), .rcv_ack(rcv_ack)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        rw;
    logic [6:0]  dev;
    logic [7:0]  rg;
    logic [3:0]  len;
    logic [63:0] wdata;
    logic [63:0] rbytes;
    int          nack;
    int          stall;
    int          n;
    logic [12:0] e0;
    logic [12:0] e2;
    logic [12:0] el;
    logic        err;
    logic [63:0] rdata;
  } vec_t;

  vec_t        vecs[9];
  logic [12:0] ent[16];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic run_cmd(input vec_t v);
    logic [8:0] pend[$];
    int  ne, rk, cyc;
    bit  fin, popped;
    ne = 0; rk = 0; cyc = 0; fin = 0;
    @(negedge CLK);
    CMD_RW = v.rw; CMD_DEV = v.dev; CMD_REG = v.rg; CMD_LEN = v.len; CMD_WDATA = v.wdata;
    CMD_GO = 1'b1;
    snd_rdy = (v.stall == 0);
    @(negedge CLK);
    // Scramble command inputs; the running command must use its latched copy.
    CMD_GO = 1'b0; CMD_RW = ~v.rw; CMD_DEV = 7'h15; CMD_REG = 8'hEE; CMD_LEN = 4'd1;
    CMD_WDATA = '1;
    chk("busy_start", {CMD_BUSY, I2C_GO, snd_vld}, 3'b111);
    for (int s = 0; s < v.stall; s++) begin
      chk("stall_entry", {snd_vld, snd_ctl, snd_dat}, {1'b1, v.e0});
      CMD_GO = (s == 1);
      @(negedge CLK);
    end
    CMD_GO = 1'b0;
    snd_rdy = 1'b1;
    while (!fin && cyc < 200) begin
      popped = 0;
      if (pend.size() > 0) begin
        {rcv_ack, rcv_dat} = pend.pop_front();
        rcv_vld = 1'b1;
        popped = 1;
      end else begin
        rcv_vld = 1'b0;
      end
      if (snd_vld) begin
        if (ne < 16) ent[ne] = {snd_ctl, snd_dat};
        if (snd_ctl[2] && rk < 8) begin
          pend.push_back({ne != v.nack, v.rbytes[8*rk +: 8]});
          rk++;
        end else begin
          pend.push_back({ne != v.nack, 8'hFF});
        end
        ne++;
      end else if (popped && pend.size() == 0) begin
        I2C_DONE = 1'b1;
        fin = 1;
      end
      @(negedge CLK);
      cyc++;
    end
    rcv_vld = 1'b0;
    if (!fin) begin
      errors++;
      $display("FAIL cmd_timeout actual=%0d cycles required=<200", cyc);
    end
    chk("done_pulse", {CMD_DONE, CMD_BUSY, I2C_GO, rcv_rdy}, 4'b1000);
    CMD_GO = 1'b1;  // lands in FIN: must be ignored
    @(negedge CLK);
    CMD_GO = 1'b0;
    chk("done_drop", {CMD_DONE, CMD_BUSY}, 2'b00);
    I2C_DONE = 1'b0;
    @(negedge CLK);
    chk("run_num", I2C_RUN_NUM, v.n);
    chk("entry_count", ne, v.n);
    chk("entry0", ent[0], v.e0);
    chk("entry2", ent[2], v.e2);
    chk("entry_last", ent[(v.n - 1) & 15], v.el);
    chk("cmd_err", CMD_ERR, v.err);
    chk("cmd_rdata", CMD_RDATA, v.rdata);
  endtask

  initial begin
    vecs[0] = '{1'b0, 7'h50, 8'h10, 4'd2, 64'hBBAA, 64'h0, -1, 0, 4,
                {5'h03, 8'hA0}, {5'h02, 8'hAA}, {5'h0A, 8'hBB}, 1'b0, 64'h0};
    vecs[1] = '{1'b1, 7'h50, 8'h20, 4'd3, 64'h0, 64'h332211, -1, 0, 6,
                {5'h03, 8'hA0}, {5'h12, 8'hA1}, {5'h0C, 8'h00}, 1'b0, 64'h332211};
    vecs[2] = '{1'b0, 7'h50, 8'h10, 4'd2, 64'hBBAA, 64'h0, 1, 0, 4,
                {5'h03, 8'hA0}, {5'h02, 8'hAA}, {5'h0A, 8'hBB}, 1'b1, 64'h0};
    vecs[3] = '{1'b0, 7'h50, 8'h10, 4'd0, 64'hCC, 64'h0, -1, 0, 3,
                {5'h03, 8'hA0}, {5'h0A, 8'hCC}, {5'h0A, 8'hCC}, 1'b0, 64'h0};
    vecs[4] = '{1'b0, 7'h50, 8'h10, 4'd15, 64'h0807060504030201, 64'h0, -1, 0, 10,
                {5'h03, 8'hA0}, {5'h02, 8'h01}, {5'h0A, 8'h08}, 1'b0, 64'h0};
    vecs[5] = '{1'b1, 7'h7F, 8'h00, 4'd0, 64'h0, 64'h5A, -1, 0, 4,
                {5'h03, 8'hFE}, {5'h12, 8'hFF}, {5'h0C, 8'h00}, 1'b0, 64'h5A};
    vecs[6] = '{1'b1, 7'h50, 8'h20, 4'd2, 64'h0, 64'hBEEF, 3, 0, 5,
                {5'h03, 8'hA0}, {5'h12, 8'hA1}, {5'h0C, 8'h00}, 1'b0, 64'hBEEF};
    vecs[7] = '{1'b1, 7'h50, 8'h20, 4'd1, 64'h0, 64'h77, 2, 0, 4,
                {5'h03, 8'hA0}, {5'h12, 8'hA1}, {5'h0C, 8'h00}, 1'b1, 64'h77};
    vecs[8] = '{1'b0, 7'h50, 8'h10, 4'd1, 64'h44, 64'h0, -1, 5, 3,
                {5'h03, 8'hA0}, {5'h0A, 8'h44}, {5'h0A, 8'h44}, 1'b0, 64'h0};

    RESET_N = 1'b0; CMD_GO = 0; CMD_RW = 0; CMD_DEV = '0; CMD_REG = '0; CMD_LEN = '0;
    CMD_WDATA = '0; I2C_DONE = 0; snd_rdy = 0; rcv_vld = 0; rcv_dat = '0; rcv_ack = 0;
    repeat (3) @(negedge CLK);
    chk("reset_ctrl", {I2C_GO, snd_vld, snd_dat, snd_ctl, rcv_rdy, I2C_RUN_NUM,
                       CMD_BUSY, CMD_DONE, CMD_ERR}, '0);
    chk("reset_rdata", CMD_RDATA, '0);
    RESET_N = 1'b1;

    for (int i = 0; i < 9; i++) run_cmd(vecs[i]);

    // Reset in the middle of a write, after two entries have transferred.
    @(negedge CLK);
    CMD_RW = 0; CMD_DEV = 7'h50; CMD_REG = 8'h10; CMD_LEN = 4'd4;
    CMD_WDATA = 64'h44332211; CMD_GO = 1'b1; snd_rdy = 1'b1;
    @(negedge CLK);
    CMD_GO = 1'b0;
    repeat (2) @(negedge CLK);
    chk("mid_entry2", {snd_vld, snd_ctl, snd_dat}, {1'b1, 5'h02, 8'h11});
    #2 RESET_N = 1'b0;
    #1;
    chk("async_reset_ctrl", {I2C_GO, snd_vld, snd_dat, snd_ctl, rcv_rdy, I2C_RUN_NUM,
                             CMD_BUSY, CMD_DONE, CMD_ERR}, '0);
    chk("async_reset_rdata", CMD_RDATA, '0);
    snd_rdy = 1'b0;
    @(negedge CLK);
    RESET_N = 1'b1;
    run_cmd(vecs[0]);
    run_cmd(vecs[1]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
